// File: rtl/vscale_ifetch_queue.sv
// Instruction fetch front end: issues in-order fetches, pairs responses with their PCs and
// buffers up to two instructions. Define VSCALE_IFQ_BYPASS_EN to let a response reach decode in its arrival cycle.
module vscale_ifetch_queue #(
  parameter int                 XPR_LEN    = 32,
  parameter int                 INST_WIDTH = 32,
  parameter logic [XPR_LEN-1:0] START_ADDR = 32'h200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XPR_LEN-1:0]    PC_PIF,
  input  logic                  redirect,
  output logic [XPR_LEN-1:0]    PC_IF,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XPR_LEN-1:0]    imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [XPR_LEN-1:0]    PC_out
);

  logic [XPR_LEN-1:0]    r_pc_if;
  logic [1:0]            r_out_cnt;
  logic [1:0]            r_occ;
  logic [1:0]            r_drop_cnt;
  logic [XPR_LEN-1:0]    r_addr_mem [2];
  logic                  r_addr_wr;
  logic                  r_addr_rd;
  logic [INST_WIDTH-1:0] r_inst_mem [2];
  logic [XPR_LEN-1:0]    r_ipc_mem  [2];
  logic                  r_inst_wr;
  logic                  r_inst_rd;

  logic [2:0]            w_sum;
  logic                  w_req_hs;
  logic                  w_resp_keep;
  logic                  w_head_valid;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_out_cnt_next;
  logic [1:0]            w_occ_next;
  logic [1:0]            w_drop_cnt_next;

  // Requests only go out while every possible response already has a queue slot.
  assign w_sum          = {1'b0, r_out_cnt} + {1'b0, r_occ};
  assign imem_req_valid = !reset && !redirect && (w_sum < 3'd2);
  assign imem_addr      = r_pc_if;
  assign PC_IF          = r_pc_if;
  assign w_req_hs       = imem_req_valid && imem_req_ready;

  assign w_resp_keep    = imem_resp_valid && !redirect && (r_drop_cnt == 2'd0);
  assign w_head_valid   = (r_occ != 2'd0);

`ifdef VSCALE_IFQ_BYPASS_EN
  assign w_bypass = w_resp_keep && !w_head_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign inst_valid = w_head_valid || w_bypass;
  assign inst_out   = w_bypass ? imem_rdata : r_inst_mem[r_inst_rd];
  assign PC_out     = w_bypass ? r_addr_mem[r_addr_rd] : r_ipc_mem[r_inst_rd];

  // A flush wins over a pop in the same cycle.
  assign w_pop  = w_head_valid && inst_ready && !redirect;
  assign w_push = w_resp_keep && !(w_bypass && inst_ready);

  always_comb begin
    w_out_cnt_next = r_out_cnt;
    if (w_req_hs && !imem_resp_valid && r_out_cnt != 2'd2) begin
      w_out_cnt_next = r_out_cnt + 2'd1;
    end else if (!w_req_hs && imem_resp_valid && r_out_cnt != 2'd0) begin
      w_out_cnt_next = r_out_cnt - 2'd1;
    end
  end

  always_comb begin
    w_occ_next = r_occ;
    if (redirect) begin
      w_occ_next = 2'd0;
    end else if (w_push && !w_pop && r_occ != 2'd2) begin
      w_occ_next = r_occ + 2'd1;
    end else if (w_pop && !w_push) begin
      w_occ_next = r_occ - 2'd1;
    end
  end

  // Everything still in flight after this cycle's response belongs to the abandoned path.
  always_comb begin
    w_drop_cnt_next = r_drop_cnt;
    if (redirect) begin
      w_drop_cnt_next = (imem_resp_valid && r_out_cnt != 2'd0) ? r_out_cnt - 2'd1 : r_out_cnt;
    end else if (imem_resp_valid && r_drop_cnt != 2'd0) begin
      w_drop_cnt_next = r_drop_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_if    <= START_ADDR;
      r_out_cnt  <= 2'd0;
      r_occ      <= 2'd0;
      r_drop_cnt <= 2'd0;
      r_addr_wr  <= 1'b0;
      r_addr_rd  <= 1'b0;
      r_inst_wr  <= 1'b0;
      r_inst_rd  <= 1'b0;
    end else begin
      if (w_req_hs || redirect) begin
        r_pc_if <= PC_PIF;
      end
      r_out_cnt  <= w_out_cnt_next;
      r_occ      <= w_occ_next;
      r_drop_cnt <= w_drop_cnt_next;
      if (w_req_hs) begin
        r_addr_wr <= ~r_addr_wr;
      end
      // Dropped responses still retire their address entry.
      if (imem_resp_valid) begin
        r_addr_rd <= ~r_addr_rd;
      end
      if (redirect) begin
        r_inst_wr <= 1'b0;
        r_inst_rd <= 1'b0;
      end else begin
        if (w_push) begin
          r_inst_wr <= ~r_inst_wr;
        end
        if (w_pop) begin
          r_inst_rd <= ~r_inst_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_mem[0] <= '0;
      r_addr_mem[1] <= '0;
      r_inst_mem[0] <= '0;
      r_inst_mem[1] <= '0;
      r_ipc_mem[0]  <= '0;
      r_ipc_mem[1]  <= '0;
    end else begin
      if (w_req_hs) begin
        r_addr_mem[r_addr_wr] <= r_pc_if;
      end
      if (w_push) begin
        r_inst_mem[r_inst_wr] <= imem_rdata;
        r_ipc_mem[r_inst_wr]  <= r_addr_mem[r_addr_rd];
      end
    end
  end

endmodule

// File: tb/tb_vscale_ifetch_queue.sv
// Directed bench for vscale_ifetch_queue with an in-order memory model (1-cycle latency, gateable).
// Bypass-specific checks are selected by VSCALE_IFQ_BYPASS_EN.
module tb_vscale_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC_PIF = 32'h204;
  logic        redirect = 1'b0;
  logic [31:0] PC_IF;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_out;
  logic [31:0] PC_out;

  int          checks = 0;
  int          errors = 0;
  bit          resp_en = 1'b1;
  logic [31:0] mem_q[$];
  logic [31:0] obs_req[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_inst[$];

  vscale_ifetch_queue dut (
    .clk(clk), .reset(reset), .PC_PIF(PC_PIF), .redirect(redirect), .PC_IF(PC_IF),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .PC_out(PC_out)
  );

  always #5 clk = ~clk;

  // One clock: record handshakes, advance the memory model, present the next response.
  task automatic cycle();
    bit          hs;
    bit          rst_s;
    logic [31:0] a;
    #1;
    hs    = imem_req_valid && imem_req_ready;
    a     = imem_addr;
    rst_s = reset;
    if (inst_valid && inst_ready) begin
      obs_pc.push_back(PC_out);
      obs_inst.push_back(inst_out);
    end
    if (hs) obs_req.push_back(a);
    if (imem_resp_valid) begin
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL resp_no_outstanding: response with 0 requests pending, required >0");
      end else begin
        void'(mem_q.pop_front());
      end
    end
    if (hs) mem_q.push_back(a);
    @(posedge clk);
    #1;
    if (rst_s) mem_q.delete();
    imem_resp_valid = !rst_s && resp_en && (mem_q.size() != 0);
    imem_rdata      = imem_resp_valid ? (32'h1000_0000 | mem_q[0]) : 32'h0;
    PC_PIF          = PC_IF + 32'd4;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; resp_en = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    obs_req.delete(); obs_pc.delete(); obs_inst.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0;
    cycle(); cycle();
    checks++; if (PC_IF !== 32'h200) begin errors++; $display("FAIL reset_pc_if: got %h expected %h", PC_IF, 32'h200); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst_out: got %h expected 0", inst_out); end
    checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h expected 0", PC_out); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL first_req_addr: got %h expected %h", imem_addr, 32'h200); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stream();
    logic [31:0] exp_req [3] = '{32'h200, 32'h204, 32'h208};
    logic [31:0] exp_pc  [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
    do_reset();
    cycle();
`ifndef VSCALE_IFQ_BYPASS_EN
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_latency_early: got %b expected 0", inst_valid); end
`endif
    cycle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_latency_valid: got %b expected 1", inst_valid); end
    checks++; if (PC_out !== 32'h200) begin errors++; $display("FAIL stream_first_pc: got %h expected %h", PC_out, 32'h200); end
    repeat (12) cycle();
    checks++;
    if (obs_req.size() < 3 || obs_pc.size() < 4) begin
      errors++; $display("FAIL stream_counts: got req=%0d pop=%0d expected >=3 and >=4", obs_req.size(), obs_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_req[i] !== exp_req[i]) begin errors++; $display("FAIL stream_req%0d: got %h expected %h", i, obs_req[i], exp_req[i]); end
      end
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL stream_pc%0d: got %h expected %h", i, obs_pc[i], exp_pc[i]); end
        checks++; if (obs_inst[i] !== (32'h1000_0000 | exp_pc[i])) begin errors++; $display("FAIL stream_inst%0d: got %h expected %h", i, obs_inst[i], 32'h1000_0000 | exp_pc[i]); end
      end
    end
    $display("test_stream done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3] = '{32'h200, 32'h204, 32'h208};
    do_reset();
    inst_ready = 1'b0;
    repeat (10) cycle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %b expected 1", inst_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (PC_IF !== 32'h208) begin errors++; $display("FAIL bp_pc_hold: got %h expected %h", PC_IF, 32'h208); end
    checks++; if (PC_out !== 32'h200) begin errors++; $display("FAIL bp_head_pc: got %h expected %h", PC_out, 32'h200); end
    checks++; if (inst_out !== 32'h1000_0200) begin errors++; $display("FAIL bp_head_inst: got %h expected %h", inst_out, 32'h1000_0200); end
    checks++; if (obs_req.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d expected 2", obs_req.size()); end
    inst_ready = 1'b1;
    repeat (10) cycle();
    checks++;
    if (obs_pc.size() < 3) begin
      errors++; $display("FAIL bp_drain_count: got %0d expected >=3", obs_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL bp_drain_pc%0d: got %h expected %h", i, obs_pc[i], exp_pc[i]); end
        checks++; if (obs_inst[i] !== (32'h1000_0000 | exp_pc[i])) begin errors++; $display("FAIL bp_drain_inst%0d: got %h expected %h", i, obs_inst[i], 32'h1000_0000 | exp_pc[i]); end
      end
    end
    $display("test_backpressure done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_redirect();
    do_reset();
    resp_en = 1'b0;
    cycle(); cycle();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_two_outstanding: got req_valid %b expected 0", imem_req_valid); end
    redirect = 1'b1; PC_PIF = 32'h400;
    cycle();
    redirect = 1'b0;
    checks++; if (PC_IF !== 32'h400) begin errors++; $display("FAIL redir_pc_if: got %h expected %h", PC_IF, 32'h400); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", inst_valid); end
    resp_en = 1'b1;
    repeat (10) cycle();
    checks++;
    if (obs_req.size() < 3 || obs_pc.size() < 2) begin
      errors++; $display("FAIL redir_counts: got req=%0d pop=%0d expected >=3 and >=2", obs_req.size(), obs_pc.size());
    end else begin
      checks++; if (obs_req[2] !== 32'h400) begin errors++; $display("FAIL redir_next_req: got %h expected %h", obs_req[2], 32'h400); end
      checks++; if (obs_pc[0] !== 32'h400) begin errors++; $display("FAIL redir_first_pc: got %h expected %h", obs_pc[0], 32'h400); end
      checks++; if (obs_inst[0] !== 32'h1000_0400) begin errors++; $display("FAIL redir_first_inst: got %h expected %h", obs_inst[0], 32'h1000_0400); end
      checks++; if (obs_pc[1] !== 32'h404) begin errors++; $display("FAIL redir_second_pc: got %h expected %h", obs_pc[1], 32'h404); end
    end
    $display("test_redirect done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_redirect_with_resp();
    do_reset();
    inst_ready = 1'b0; resp_en = 1'b0;
    cycle(); cycle();
    resp_en = 1'b1;
    cycle();
    redirect = 1'b1; PC_PIF = 32'h300;
    cycle();
    redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rr_same_cycle_dropped: got %b expected 0", inst_valid); end
    checks++; if (PC_IF !== 32'h300) begin errors++; $display("FAIL rr_pc_if: got %h expected %h", PC_IF, 32'h300); end
    cycle(); cycle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rr_target_valid: got %b expected 1", inst_valid); end
    checks++; if (PC_out !== 32'h300) begin errors++; $display("FAIL rr_target_pc: got %h expected %h", PC_out, 32'h300); end
    checks++; if (inst_out !== 32'h1000_0300) begin errors++; $display("FAIL rr_target_inst: got %h expected %h", inst_out, 32'h1000_0300); end
    $display("test_redirect_with_resp done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_ready = 1'b0;
    repeat (4) cycle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", inst_valid); end
    reset = 1'b1;
    cycle();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (PC_IF !== 32'h200) begin errors++; $display("FAIL mid_pc_if: got %h expected %h", PC_IF, 32'h200); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid: got %b expected 0", imem_req_valid); end
    reset = 1'b0; inst_ready = 1'b1;
    obs_pc.delete(); obs_inst.delete(); obs_req.delete();
    #1;
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL mid_restart_addr: got %h expected %h", imem_addr, 32'h200); end
    repeat (6) cycle();
    checks++;
    if (obs_pc.size() < 1) begin
      errors++; $display("FAIL mid_restart_count: got %0d expected >=1", obs_pc.size());
    end else if (obs_pc[0] !== 32'h200) begin
      errors++; $display("FAIL mid_restart_pc: got %h expected %h", obs_pc[0], 32'h200);
    end
    $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef VSCALE_IFQ_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    cycle();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL byp_valid: got %b expected 1", inst_valid); end
    checks++; if (PC_out !== 32'h200) begin errors++; $display("FAIL byp_pc: got %h expected %h", PC_out, 32'h200); end
    checks++; if (inst_out !== 32'h1000_0200) begin errors++; $display("FAIL byp_inst: got %h expected %h", inst_out, 32'h1000_0200); end
    cycle();
    checks++; if (PC_out !== 32'h204) begin errors++; $display("FAIL byp_not_enqueued: got %h expected %h", PC_out, 32'h204); end
    $display("test_bypass done: checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_with_resp();
    test_reset_mid();
`ifdef VSCALE_IFQ_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_ifetch_queue.md
VSCALE_IFETCH_QUEUE -- requirements
Module: vscale_ifetch_queue

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h200: fetch PC loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PC_PIF  input  XPR_LEN  next fetch PC from the PC mux.
REQ-005 SHALL have port redirect  input  1  control transfer taken this cycle; PC_PIF holds the target.
REQ-006 SHALL have port PC_IF  output  XPR_LEN  current fetch PC; fed back to the PC mux.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-009 SHALL have port imem_addr  output  XPR_LEN  request address, equal to PC_IF.
REQ-010 SHALL have port imem_resp_valid  input  1  in-order response valid.
REQ-011 SHALL have port imem_rdata  input  INST_WIDTH  response instruction word.
REQ-012 SHALL have port inst_valid  output  1  instruction available to decode.
REQ-013 SHALL have port inst_ready  input  1  decode consumes the instruction.
REQ-014 SHALL have port inst_out  output  INST_WIDTH  instruction at queue head.
REQ-015 SHALL have port PC_out  output  XPR_LEN  PC of inst_out.

Function
REQ-016 SHALL accept a request only on imem_req_valid && imem_req_ready (handshake).
REQ-017 SHALL update PC_IF <= PC_PIF on the handshake or on redirect; otherwise PC_IF SHALL hold.
REQ-018 SHALL track outstanding requests (0..2) and queued instructions (0..2) and drive imem_req_valid = !redirect && (outstanding + occupancy) < 2, so responses never overflow the queue.
REQ-019 SHALL record each accepted address in a 2-entry in-order address FIFO and pair it with the matching response as PC_out.
REQ-020 SHALL write each non-dropped response into a 2-entry instruction FIFO one cycle after imem_resp_valid (no bypass, see REQ-031).
REQ-021 SHALL assert inst_valid whenever occupancy > 0 and pop the head on inst_valid && inst_ready.
REQ-022 SHALL support simultaneous push and pop at occupancy 2 without loss.
REQ-023 On redirect SHALL flush the instruction FIFO (occupancy 0 next cycle), deassert inst_valid the next cycle, and set drop_cnt to the number of requests still in flight after counting any response arriving that cycle.
REQ-024 SHALL discard responses while drop_cnt > 0, decrementing per discarded response; discarded responses SHALL NOT affect occupancy or PC_out.
REQ-025 A response arriving in the same cycle as redirect SHALL be discarded.
REQ-026 Redirect with pop in the same cycle SHALL give priority to the flush.
REQ-027 Counters SHALL never wrap; imem_resp_valid with no outstanding request is illegal, and the bench SHALL flag it.

Reset
REQ-028 On reset SHALL set PC_IF = START_ADDR, outstanding = 0, occupancy = 0, drop_cnt = 0, inst_valid = 0, imem_req_valid = 0 during reset, inst_out = 0, PC_out = 0.
REQ-029 Reset asserted mid-operation SHALL abandon in-flight requests; the memory side SHALL be reset by the same signal.
REQ-030 The first request SHALL be issued in the cycle after reset deasserts, at START_ADDR.

Configuration
REQ-031 With VSCALE_IFQ_BYPASS_EN defined: a non-dropped response arriving at occupancy 0 SHALL drive inst_valid, inst_out and PC_out combinationally in the same cycle, and SHALL not be enqueued if inst_ready is high. Without it: response-to-inst_valid latency SHALL be exactly 1 cycle.

Verification
REQ-032 Reset, then imem_req_ready=1 with 1-cycle response latency and PC_PIF=PC_IF+4 -> requests at 0x200, 0x204, 0x208; PC_out sequence 0x200, 0x204, ... with matching imem_rdata.
REQ-033 inst_ready=0 for 10 cycles -> occupancy reaches 2, imem_req_valid drops, no response lost; release -> in-order drain.
REQ-034 Two requests outstanding, then redirect with PC_PIF=0x400 -> both later responses dropped; the next request is at 0x400 and the first inst_out has PC_out=0x400.
REQ-035 Redirect in the same cycle as imem_resp_valid -> that response is not delivered; drop_cnt equals the remaining in-flight requests.
REQ-036 Reset asserted with occupancy 2 -> next cycle inst_valid=0 and PC_IF=0x200.
REQ-037 Build with VSCALE_IFQ_BYPASS_EN, empty queue, response with inst_ready=1 -> inst_valid is high in the same cycle and occupancy stays 0.
